// File: rtl/fdiv_seq.sv
// rtl/fdiv_seq.sv - iterative single-precision divider y = x1 / x2, restoring radix-2^STEP
// Define FDIV_SEQ_RNE_EN for round-to-nearest-even; default build rounds half up.
module fdiv_seq #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf
);
    localparam int N = 26 / STEP;
    localparam logic [4:0] LAST = 5'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, PACK, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] a, b;
    logic [24:0] r, r_nx;
    logic [25:0] q, q_nx;
    logic [4:0]  cnt;
    logic [24:0] my;
    logic [31:0] y_nx;
    logic        ovf_nx;

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = BUSY;
            end
            BUSY: if (cnt == LAST) state_nx = PACK;
            PACK: state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign my = {2'b01, b[22:0]};

    // r stays below 2*my, so 25 bits never overflow across the shift.
    always_comb begin
        r_nx = r;
        q_nx = q;
        for (int i = 0; i < STEP; i++) begin
            if (r_nx >= my) begin
                r_nx = r_nx - my;
                q_nx = {q_nx[24:0], 1'b1};
            end else begin
                q_nx = {q_nx[24:0], 1'b0};
            end
            r_nx = {r_nx[23:0], 1'b0};
        end
    end

    logic              s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic              rnd, inc, carry;
    logic [23:0]       mant;
    logic [22:0]       frac;
    logic signed [9:0] e_base, e_fin;
`ifdef FDIV_SEQ_RNE_EN
    logic              sticky;
`endif

    always_comb begin
        s      = a[31] ^ b[31];
        nan_a  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nan_b  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        inf_a  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        inf_b  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        zero_a = (a[30:23] == 8'h00);
        zero_b = (b[30:23] == 8'h00);

        mant   = q[25] ? q[25:2] : q[24:1];
        rnd    = q[25] ? q[1] : q[0];
        e_base = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]})
               + (q[25] ? 10'sd127 : 10'sd126);
`ifdef FDIV_SEQ_RNE_EN
        sticky = (r != 25'd0) | (q[25] & q[0]);
        inc    = rnd & (sticky | mant[0]);
`else
        inc    = rnd;
`endif
        // An all-ones mantissa wraps the fraction to zero and bumps the exponent.
        carry  = (&mant) & inc;
        frac   = mant[22:0] + {22'd0, inc};
        e_fin  = e_base + {9'd0, carry};

        ovf_nx = 1'b0;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            y_nx = 32'h7FC0_0000;
        end else if (inf_a) begin
            y_nx = {s, 8'hFF, 23'd0};
        end else if (zero_b) begin
            y_nx   = {s, 8'hFF, 23'd0};
            ovf_nx = 1'b1;
        end else if (inf_b || zero_a) begin
            y_nx = {s, 31'd0};
        end else if (e_fin >= 10'sd255) begin
            y_nx   = {s, 8'hFF, 23'd0};
            ovf_nx = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            y_nx = {s, 31'd0};
        end else begin
            y_nx = {s, e_fin[7:0], frac};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            a   <= '0;
            b   <= '0;
            r   <= '0;
            q   <= '0;
            cnt <= '0;
            y   <= '0;
            ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a   <= x1;
                    b   <= x2;
                    r   <= {2'b01, x1[22:0]};
                    q   <= '0;
                    cnt <= '0;
                end
                BUSY: begin
                    r   <= r_nx;
                    q   <= q_nx;
                    cnt <= cnt + 5'd1;
                end
                PACK: begin
                    y   <= y_nx;
                    ovf <= ovf_nx;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fdiv_seq.sv
// tb/tb_fdiv_seq.sv - randomized bench for fdiv_seq against an integer-division reference model
module tb_fdiv_seq;
    localparam int STEP = 1;
    localparam int N    = 26 / STEP;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] x1 = '0, x2 = '0;
    logic        in_ready, out_valid, ovf;
    logic [31:0] y;

    int n_tests = 0;
    int n_fail  = 0;

    fdiv_seq #(.STEP(STEP)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .x1(x1), .x2(x2),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {ovf, y}; quotient digits come from one wide integer division.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        s, nan_a, nan_b, inf_a, inf_b, z_a, z_b, rb, st, inc;
        int          ea, eb, e;
        longint      num, den, qf, rem;
        logic [25:0] qv;
        logic [23:0] mant;
        s     = a[31] ^ b[31];
        ea    = int'(a[30:23]);
        eb    = int'(b[30:23]);
        nan_a = (ea == 255) && (a[22:0] != 0);
        nan_b = (eb == 255) && (b[22:0] != 0);
        inf_a = (ea == 255) && (a[22:0] == 0);
        inf_b = (eb == 255) && (b[22:0] == 0);
        z_a   = (ea == 0);
        z_b   = (eb == 0);
        if (nan_a || nan_b || (z_a && z_b) || (inf_a && inf_b)) return {1'b0, 32'h7FC0_0000};
        if (inf_a) return {1'b0, s, 8'hFF, 23'd0};
        if (z_b) return {1'b1, s, 8'hFF, 23'd0};
        if (inf_b || z_a) return {1'b0, s, 31'd0};
        num = longint'({1'b1, a[22:0]}) << 25;
        den = longint'({1'b1, b[22:0]});
        qf  = num / den;
        rem = num % den;
        qv  = qf[25:0];
        if (qv[25]) begin
            mant = qv[25:2]; rb = qv[1]; st = qv[0] | (rem != 0); e = ea - eb + 127;
        end else begin
            mant = qv[24:1]; rb = qv[0]; st = (rem != 0); e = ea - eb + 126;
        end
`ifdef FDIV_SEQ_RNE_EN
        inc = rb & (st | mant[0]);
`else
        inc = rb;
`endif
        if (int'(mant) + int'(inc) == (1 << 24)) begin
            mant = 24'h800000;
            e++;
        end else begin
            mant = mant + 24'(inc);
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
        if (e <= 0) return {1'b0, s, 31'd0};
        return {1'b0, s, e[7:0], mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int          sel, e;
        logic [31:0] f;
        sel = $urandom_range(0, 15);
        f   = $urandom;
        if (sel == 0)      e = 0;
        else if (sel == 1) e = 255;
        else if (sel < 6)  e = $urandom_range(1, 254);
        else               e = $urandom_range(110, 144);
        if (sel == 1 && $urandom_range(0, 1) == 0) f = 0;
        if (sel == 2) f = 0;
        return {f[31], 8'(e), f[22:0]};
    endfunction

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 200) begin
            @(posedge clk); #1; k++;
        end
        if (!in_ready) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic wait_result(input string tag);
        int lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_lat"}, lat, N + 1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag,
                          output logic [31:0] yo, output logic ovfo);
        logic [32:0] exp;
        wait_ready();
        x1 = a; x2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(tag);
        exp = ref_div(a, b);
        yo   = y;
        ovfo = ovf;
        check({tag, "_y"}, y, exp[31:0]);
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp[32]});
    endtask

    task automatic run_fixed(input logic [31:0] a, input logic [31:0] b, input string tag,
                             input logic [31:0] ey, input logic eovf);
        logic [31:0] yo;
        logic        ovfo;
        run_op(a, b, tag, yo, ovfo);
        check({tag, "_ylit"}, yo, ey);
        check({tag, "_ovflit"}, {31'd0, ovfo}, {31'd0, eovf});
    endtask

    initial begin
        logic [31:0] yo, held;
        logic        ovfo;
        logic [32:0] exp;
        int          seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        rstn = 1'b1;

        run_fixed(32'h40C00000, 32'h40000000, "six_by_two", 32'h40400000, 1'b0);
        run_fixed(32'h3F800000, 32'h40400000, "one_third", 32'h3EAAAAAB, 1'b0);
        run_fixed(32'h3F800000, 32'h00000000, "div_zero", 32'h7F800000, 1'b1);
        run_fixed(32'h00000000, 32'h00000000, "zero_zero", 32'h7FC00000, 1'b0);
        run_fixed(32'h7F000000, 32'h00800000, "exp_ovf", 32'h7F800000, 1'b1);
        run_fixed(32'h00800000, 32'h7F000000, "exp_unf", 32'h00000000, 1'b0);
        run_fixed(32'h7F800000, 32'hFF800000, "inf_inf", 32'h7FC00000, 1'b0);
        run_fixed(32'hFF800000, 32'h40000000, "inf_x", 32'hFF800000, 1'b0);
        run_fixed(32'h40000000, 32'hFF800000, "x_inf", 32'h80000000, 1'b0);
        run_fixed(32'h7FC00001, 32'h3F800000, "nan_x", 32'h7FC00000, 1'b0);
        run_fixed(32'h00400000, 32'h3F800000, "denorm_x", 32'h00000000, 1'b0);
        run_fixed(32'hC0C00000, 32'h40000000, "neg_six", 32'hC0400000, 1'b0);

        for (int i = 0; i < 150; i++) run_op(rand_op(), rand_op(), "rand", yo, ovfo);

        // Backpressure with the next operands already waiting on in_valid.
        wait_ready();
        out_ready = 1'b0;
        x1 = 32'h40C00000; x2 = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        x1 = 32'h3F800000; x2 = 32'h40400000;
        wait_result("bp1");
        held = y;
        check("bp1_y", y, 32'h40400000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_y", y, held);
            check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("bp_second_accept", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        wait_result("bp2");
        exp = ref_div(32'h3F800000, 32'h40400000);
        check("bp2_y", y, exp[31:0]);

        // Reset while iterating.
        wait_ready();
        x1 = 32'h3F800000; x2 = 32'h40400000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_y", y, 32'd0);
        check("abort_ovf", {31'd0, ovf}, 32'd0);
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < N + 3; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 0);
        run_fixed(32'h40C00000, 32'h40000000, "post_reset", 32'h40400000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fdiv_seq.md
# fdiv_seq

- Iterative single-precision floating-point divider: y = x1 / x2.
- Sits in the FPU alongside the pipelined add/sub/mul units; used for divide ops the fixed-latency pipeline does not cover.
- Restoring radix-2^STEP quotient generation with a valid/ready handshake on both sides.
- Fixed latency regardless of operand values, including special cases.

## Interface
- STEP, default 1: quotient bits per iteration cycle; legal values 1 or 2. N = 26/STEP iteration cycles.
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- in_valid  in  1  operands present
- in_ready  out  1  divider idle, can accept
- x1  in  32  dividend, IEEE-754 single
- x2  in  32  divisor, IEEE-754 single
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- y  out  32  quotient
- ovf  out  1  exponent overflow or divide-by-zero

## Operation
- FSM: IDLE -> BUSY -> PACK -> DONE -> IDLE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
- IDLE: on in_valid & in_ready:
  - latch sign sx1^sx2, exponents, mantissas mx = {1,x1[22:0]}, my = {1,x2[22:0]};
  - remainder r = mx; clear the iteration counter.
- BUSY, each cycle, STEP times:
  - if r >= my: q bit = 1, r -= my; else q bit = 0;
  - then r <<= 1.
  - r is 25 bits wide. q is 26 bits; its MSB has weight 2^0.
  - After N cycles -> PACK.
- PACK: normalise, round and special-case; register y and ovf; -> DONE.
  - q[25]=1: mantissa q[25:2], round bit q[1], e = ex - ey + 127.
  - q[25]=0: mantissa q[24:1], round bit q[0], e = ex - ey + 126.
  - Round: mantissa += round bit. On carry-out: mantissa = 0x800000, e += 1.
  - e >= 255 (signed 10-bit arithmetic): y = {s, 0xFF, 0}, ovf = 1.
  - e <= 0: y = {s, 0x00, 0}, ovf = 0; no denormal outputs.
- Special cases:
  - Evaluated in PACK from the latched operands; priority top to bottom.
  - An input with exponent 0 is treated as zero (denormals flushed).
  - x1 or x2 NaN, 0/0, or inf/inf: y = 0x7FC00000, ovf = 0.
  - x1 inf: y = {s, 0xFF, 0}, ovf = 0.
  - x2 zero: y = {s, 0xFF, 0}, ovf = 1.
  - x2 inf or x1 zero: y = {s, 0, 0}, ovf = 0.
- DONE: y and ovf held stable until out_ready = 1, then -> IDLE.
- in_valid while busy is ignored; the source must hold it.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, y 0, ovf 0, counter 0.
- Acceptance at edge k; iterations at edges k+1 .. k+N; PACK at edge k+N+1.
- out_valid high from edge k+N+1. STEP=1: 27 cycles; STEP=2: 14 cycles.
- If out_ready is already high when DONE is entered, DONE lasts one cycle; in_ready returns at edge k+N+2.
- Minimum accept-to-accept spacing: N+3 edges.
- No combinational path from in_valid/out_ready to in_ready/out_valid.
- Reset mid-operation aborts; no out_valid is produced for the aborted operation.
- Reset overrides a simultaneous accept or out handshake.

## Configuration
- FDIV_SEQ_RNE_EN defined:
  - round to nearest even;
  - sticky = (final r != 0) OR any dropped q bits below the round bit;
  - increment iff round & (sticky | mantissa LSB).
- Undefined (default): round half up; mantissa += round bit, sticky ignored.
- Latency, handshake and special cases are identical in both builds.

## Test plan
- 0x40C00000 / 0x40000000 (6/2), STEP=1, out_ready=1 -> out_valid 27 cycles after accept; y=0x40400000, ovf=0.
- 0x3F800000 / 0x40400000 (1/3), both macro settings -> y=0x3EAAAAAB, ovf=0.
- 0x3F800000 / 0x00000000 -> y=0x7F800000, ovf=1; 0x00000000 / 0x00000000 -> y=0x7FC00000, ovf=0.
- 0x7F000000 / 0x00800000 -> y=0x7F800000, ovf=1; 0x00800000 / 0x7F000000 -> y=0x00000000, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, in_valid held high -> y stable, in_ready=0 throughout; second op accepted one cycle after out_ready rises.
- rstn=0 at iteration 10 -> next cycle out_valid=0, in_ready=1, y=0; a fresh 6/2 then completes correctly.
